bram_fifo: RTL and testbench
============================

Name:
bram_fifo

Overview:
- Synchronous single-clock FIFO: 8-bit data, storage in an inferred block RAM with a registered read port.
- Sits between a producer and a consumer in the same clock domain and buffers a byte stream.
- Provides Empty/Full status flags.
- The registered read gives Read_data a one-clock latency after a read is accepted.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; FIFO depth = 2**ADDR_W = 16 words.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Read  input  1  read request; accepted when FIFO_Empty=0.
- Write  input  1  write request; accepted when FIFO_Full=0, or when a read is accepted in the same cycle.
- Write_data  input  DATA_W  data written on an accepted write.
- FIFO_Empty  output  1  high when occupancy = 0.
- FIFO_Full  output  1  high when occupancy = depth.
- Read_data  output  DATA_W  registered read data; holds its last value between reads.

Behaviour:
- Reset (async, active-high, overrides everything):
  - write pointer = 0, read pointer = 0, occupancy = 0.
  - FIFO_Empty=1, FIFO_Full=0, Read_data=0.
  - RAM contents are not cleared.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - Empty when wr_ptr == rd_ptr.
  - Full when the address bits are equal and the MSBs differ.
  - Both flags are registered (or derived combinationally from the registered pointers) and are valid in the cycle after the edge.
- Accepted write (wr_en = Write & (~FIFO_Full | rd_en)):
  - mem[wr_ptr[ADDR_W-1:0]] <= Write_data.
  - wr_ptr increments, wrapping modulo 2**(ADDR_W+1).
- Accepted read (rd_en = Read & ~FIFO_Empty):
  - Read_data <= mem[rd_ptr[ADDR_W-1:0]] at that edge, so data is visible one clock after Read is sampled.
  - rd_ptr increments.
- Rejected read (Read while empty):
  - Ignored; rd_ptr and Read_data unchanged.
- Rejected write (Write while full with no accepted read):
  - Ignored; no memory write, wr_ptr unchanged.
- Simultaneous read and write:
  - When not empty: both accepted, occupancy unchanged. The read returns the old head word, not the incoming word.
  - When empty: only the write is accepted. Empty deasserts next cycle; the word is readable from the following cycle.
  - When full: both accepted; Full stays high.
- Wrap-around: the addresses roll from depth-1 to 0 transparently, and the flags stay correct across any number of wraps.
- Reset asserted mid-operation: immediate return to the reset state; queued data is discarded.
- No combinational path from Write_data to Read_data.

Optional Feature:
- Macro: FIFO_COUNT_EN.
- When defined:
  - Adds output port Fill_count, width ADDR_W+1, giving the current occupancy 0..depth.
  - Fill_count is registered, reset to 0, and updated on the same edge as the pointers: +1 on write only, -1 on read only, unchanged on both or neither.
- When undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert Reset=1 for 1 cycle -> FIFO_Empty=1, FIFO_Full=0, Read_data=0x00. Also assert Reset asynchronously mid-cycle -> outputs return to these values before the next edge.
- Single write then read:
  - Write=1 with Write_data=0x02 for one edge -> Empty=0.
  - Then Read=1 -> Read_data=0x02 after that edge; Empty=1 afterwards.
- Continuous streaming:
  - Write=1 for one cycle (0x02), then Write=1 and Read=1 together with data 0x03..0x0A on successive cycles.
  - Read_data sequence: 0x02, 0x03, 0x04, ...; each value appears exactly one edge after the cycle in which it was written.
  - Empty never asserts during the stream; Full never asserts.
- Fill to full:
  - Write 16 words 0x00..0x0F with no reads -> Full=1 after the 16th edge.
  - A 17th write of 0xFF is ignored.
  - Then 16 reads return 0x00..0x0F in order; Empty=1 after the last.
- Read on empty: Read=1 with FIFO empty -> Read_data unchanged, pointers unchanged, Empty stays 1.
- Wrap and boundaries:
  - Perform 40 mixed writes/reads to wrap the pointers at least twice -> data order preserved.
  - Simultaneous read+write while full -> Full stays 1, head word returned.
  - Read+write while empty -> only the write takes effect.
  - With FIFO_COUNT_EN defined, Fill_count matches the reference occupancy on every cycle.

Source files
------------

// File: rtl/bram_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo
// Description : Single-clock byte FIFO with storage in an inferred block RAM
//               and a registered read port. Read_data appears one clock after
//               a read is accepted and holds its value between reads.
// Ports       : Clk        - system clock, rising-edge active
//               Reset      - asynchronous, active-high reset
//               Read       - read request, accepted when not empty
//               Write      - write request, accepted when not full or when a
//                            read is accepted on the same edge
//               Write_data - data stored on an accepted write
//               FIFO_Empty - occupancy is zero
//               FIFO_Full  - occupancy equals depth
//               Read_data  - registered read data
//               Fill_count - current occupancy (only with FIFO_COUNT_EN)
// Options     : `define FIFO_COUNT_EN to add the Fill_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] Write_data,
    output logic              FIFO_Empty,
    output logic              FIFO_Full,
    output logic [DATA_W-1:0] Read_data
`ifdef FIFO_COUNT_EN
    ,
    output logic [ADDR_W:0]   Fill_count
`endif
);

    localparam int            c_DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits coincide.
    logic [ADDR_W:0]   r_wr_ptr_q;
    logic [ADDR_W:0]   w_wr_ptr_d;
    logic [ADDR_W:0]   r_rd_ptr_q;
    logic [ADDR_W:0]   w_rd_ptr_d;
    logic [DATA_W-1:0] r_read_data_q;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_empty;
    logic              w_full;
    logic              w_rd_en;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    // Flags come straight from the registered pointers, so they respond to an
    // asynchronous reset without waiting for a clock edge.
    always_comb begin
        w_empty   = (r_wr_ptr_q == r_rd_ptr_q);
        w_full    = (r_wr_ptr_q[ADDR_W-1:0] == r_rd_ptr_q[ADDR_W-1:0]) &&
                    (r_wr_ptr_q[ADDR_W] != r_rd_ptr_q[ADDR_W]);
        w_rd_en   = Read & ~w_empty;
        // A write into a full FIFO is allowed when the head is leaving on
        // the same edge; the slot being overwritten is the one being read.
        w_wr_en   = Write & (~w_full | w_rd_en);
        w_wr_addr = r_wr_ptr_q[ADDR_W-1:0];
        w_rd_addr = r_rd_ptr_q[ADDR_W-1:0];
    end

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (w_wr_en) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
        end
        if (w_rd_en) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    // RAM array: no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= Write_data;
        end
    end

    // Registered read port. Reading and writing the same address on one edge
    // returns the old word (read-before-write).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_read_data_q <= '0;
        end else if (w_rd_en) begin
            r_read_data_q <= r_mem[w_rd_addr];
        end
    end

    assign FIFO_Empty = w_empty;
    assign FIFO_Full  = w_full;
    assign Read_data  = r_read_data_q;

`ifdef FIFO_COUNT_EN
    logic [ADDR_W:0] r_count_q;
    logic [ADDR_W:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_d = r_count_q + c_PTR_ONE;
            2'b01:   w_count_d = r_count_q - c_PTR_ONE;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign Fill_count = r_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_fifo
// Description : Directed self-checking bench for bram_fifo. A table of
//               hand-computed vectors covers reset, single transfer,
//               streaming and empty corner cases; hand-written sequences
//               cover fill-to-full, full read+write, wrap-around and an
//               asynchronous mid-cycle reset. A simple queue tracks occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_fifo;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              empty;
    logic              full;
    logic [DATA_W-1:0] rdata;
`ifdef FIFO_COUNT_EN
    logic [ADDR_W:0]   fill;
`endif

    bram_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Read       (rd),
        .Write      (wr),
        .Write_data (wdata),
        .FIFO_Empty (empty),
        .FIFO_Full  (full),
        .Read_data  (rdata)
`ifdef FIFO_COUNT_EN
        ,
        .Fill_count (fill)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference contents and the last value the read port should show.
    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] model_rdata;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
        logic              exp_empty;
        logic              exp_full;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the reference queue, sample 1 ns after the edge.
    task automatic cycle(input logic r, input logic w, input logic [DATA_W-1:0] d);
        bit acc_rd;
        bit acc_wr;
        rd    = r;
        wr    = w;
        wdata = d;
        acc_rd = r && (model_q.size() > 0);
        acc_wr = w && ((model_q.size() < DEPTH) || acc_rd);
        if (acc_rd) model_rdata = model_q.pop_front();
        if (acc_wr) model_q.push_back(d);
        @(posedge clk);
        #1;
`ifdef FIFO_COUNT_EN
        chk("fill_count", 32'(fill), 32'(model_q.size()));
`endif
    endtask

    task automatic cycle_model(input string name, input logic r, input logic w,
                               input logic [DATA_W-1:0] d);
        cycle(r, w, d);
        chk({name, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({name, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
        chk({name, "_rdata"}, 32'(rdata), 32'(model_rdata));
    endtask

    initial begin
        // rd, wr, wdata, empty, full, rdata -- hand-computed
        vecs[0]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00}; // single write
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02}; // single read
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02}; // read on empty ignored
        vecs[3]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h02}; // stream prime
        vecs[4]  = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 8'h02};
        vecs[5]  = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 8'h03};
        vecs[6]  = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h04};
        vecs[7]  = '{1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 8'h05};
        vecs[8]  = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 8'h06};
        vecs[9]  = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 8'h07};
        vecs[10] = '{1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 8'h08};
        vecs[11] = '{1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 8'h09};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0A}; // drain stream
        vecs[13] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h0A}; // rd+wr on empty
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55}; // read on empty

        rst = 1'b1; rd = 1'b0; wr = 1'b0; wdata = '0;
        model_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full",  32'(full),  32'd0);
        chk("reset_rdata", 32'(rdata), 32'h00);
`ifdef FIFO_COUNT_EN
        chk("reset_fill",  32'(fill),  32'd0);
`endif

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].rd, vecs[i].wr, vecs[i].wdata);
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_full",  i), 32'(full),  32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
        end

        // Fill to full: Full only after the 16th write.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'(i));
            chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == DEPTH - 1));
            chk($sformatf("fill%0d_empty", i), 32'(empty), 32'd0);
        end
        // 17th write is dropped.
        cycle(1'b0, 1'b1, 8'hFF);
        chk("overflow_full",  32'(full),  32'd1);
        chk("overflow_rdata", 32'(rdata), 32'h55);
        // 16 reads return 0x00..0x0F in order.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            chk($sformatf("drain%0d_rdata", i), 32'(rdata), 32'(i));
            chk($sformatf("drain%0d_full", i), 32'(full), 32'd0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Refill, then simultaneous read+write while full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i));
        chk("refill_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 8'hAA);
        chk("fullrw_full",  32'(full),  32'd1);
        chk("fullrw_rdata", 32'(rdata), 32'h30);
        // Head is now 0x31; the incoming 0xAA sits at the tail.
        cycle_model("fullrw_next", 1'b1, 1'b0, 8'h00);
        chk("fullrw_next_val", 32'(rdata), 32'h31);
        for (int i = 0; i < DEPTH - 2; i++) cycle_model("fullrw_drain", 1'b1, 1'b0, 8'h00);
        cycle_model("fullrw_last", 1'b1, 1'b0, 8'h00);
        chk("fullrw_last_val", 32'(rdata), 32'hAA);

        // Mixed traffic to wrap the pointers several more times.
        for (int i = 0; i < 80; i++) begin
            cycle_model($sformatf("wrap%0d", i), (i % 3) != 0, (i % 4) != 3,
                        8'(8'h80 + i));
        end
        // Drain what is left and confirm order.
        for (int i = 0; i < DEPTH + 1; i++) cycle_model("wrap_drain", 1'b1, 1'b0, 8'h00);

        // Asynchronous reset mid-cycle with a full FIFO and non-zero Read_data.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i));
        cycle(1'b1, 1'b1, 8'hEE);
        rd = 1'b0; wr = 1'b0;
        chk("pre_areset_full", 32'(full), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_empty", 32'(empty), 32'd1);
        chk("areset_full",  32'(full),  32'd0);
        chk("areset_rdata", 32'(rdata), 32'h00);
`ifdef FIFO_COUNT_EN
        chk("areset_fill",  32'(fill),  32'd0);
`endif
        model_q.delete();
        model_rdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Queued data discarded: a read after reset is ignored.
        cycle_model("post_reset_rd", 1'b1, 1'b0, 8'h00);
        cycle_model("post_reset_wr", 1'b0, 1'b1, 8'h5A);
        cycle_model("post_reset_rd2", 1'b1, 1'b0, 8'h00);
        chk("post_reset_val", 32'(rdata), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
